// File: rtl/icache_nwa_wide_pkg.sv
// Shared types, widths and helpers for the N-way line-wide instruction cache.
package icache_nwa_wide_pkg;

    localparam int unsigned ADDR_W     = 32;
    localparam int unsigned WORD_W     = 32;
    localparam int unsigned BYTE_OFF_W = 2;
    localparam int unsigned CNT_W      = 32;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_FILL = 2'd1,
        S_RESP = 2'd2
    } state_t;

    // Counter increment that sticks at all-ones
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == '1) ? v : v + CNT_W'(1);
    endfunction

endpackage

// File: rtl/icache_nwa_wide_if.sv
// Fetch-side and line-memory-side handshake bundle; slave is the cache view.
interface icache_nwa_wide_if #(
    parameter int unsigned NUM_BLOCKS = 4
);
    logic                                              proc_valid;
    logic                                              proc_ready;
    logic [icache_nwa_wide_pkg::ADDR_W-1:0]            proc_addr;
    logic [icache_nwa_wide_pkg::WORD_W-1:0]            proc_rdata;
    logic                                              flush;
    logic                                              mem_req_valid;
    logic                                              mem_req_ready;
    logic [icache_nwa_wide_pkg::ADDR_W-1:0]            mem_req_addr;
    logic [icache_nwa_wide_pkg::WORD_W*NUM_BLOCKS-1:0] mem_req_rdata;

    modport slave (
        input  proc_valid, proc_addr, flush, mem_req_ready, mem_req_rdata,
        output proc_ready, proc_rdata, mem_req_valid, mem_req_addr
    );

    modport master (
        output proc_valid, proc_addr, flush, mem_req_ready, mem_req_rdata,
        input  proc_ready, proc_rdata, mem_req_valid, mem_req_addr
    );
endinterface

// File: rtl/icache_nwa_wide_victim_sel.sv
// Per-set round-robin pointers plus lowest-invalid-way-first victim choice.
module icache_nwa_wide_victim_sel #(
    parameter  int unsigned NUM_WAYS = 2,
    parameter  int unsigned NUM_SETS = 32,
    localparam int unsigned WAY_W    = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1,
    localparam int unsigned SET_W    = $clog2(NUM_SETS)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [SET_W-1:0]    set_idx,
    input  logic [NUM_WAYS-1:0] way_valid,
    input  logic                evict,
    output logic [WAY_W-1:0]    victim_c
);

    logic [WAY_W-1:0] rr_q [NUM_SETS];

    // Pointer only moves when a valid line is actually displaced
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int s = 0; s < int'(NUM_SETS); s++) rr_q[s] <= '0;
        end else if (evict) begin
            rr_q[set_idx] <= (rr_q[set_idx] == WAY_W'(NUM_WAYS - 1)) ? '0
                                                                     : rr_q[set_idx] + WAY_W'(1);
        end
    end

    always_comb begin
        victim_c = rr_q[set_idx];
        for (int w = int'(NUM_WAYS) - 1; w >= 0; w--) begin
            if (!way_valid[w]) victim_c = WAY_W'(w);
        end
    end

endmodule

// File: rtl/icache_nwa_wide.sv
// N-way set-associative instruction cache: 1-cycle hits, whole-line fills,
// global flush, saturating hit/miss counters.
module icache_nwa_wide
    import icache_nwa_wide_pkg::*;
#(
    parameter int unsigned CACHE_SIZE = 1024,
    parameter int unsigned NUM_WAYS   = 2,
    parameter int unsigned NUM_BLOCKS = 4,
    parameter int unsigned BLOCK_SIZE = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    icache_nwa_wide_if.slave      bus,
    output logic                  debug_miss,
    output logic [CNT_W-1:0]      hit_count,
    output logic [CNT_W-1:0]      miss_count
);

    localparam int unsigned NUM_SETS   = CACHE_SIZE / (NUM_WAYS * NUM_BLOCKS * BLOCK_SIZE);
    localparam int unsigned OFF_W      = $clog2(NUM_BLOCKS);
    localparam int unsigned SET_W      = $clog2(NUM_SETS);
    localparam int unsigned WAY_W      = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1;
    localparam int unsigned LINE_OFF_W = BYTE_OFF_W + OFF_W;
    localparam int unsigned TAG_W      = ADDR_W - SET_W - LINE_OFF_W;
    localparam int unsigned LINE_W     = WORD_W * NUM_BLOCKS;

    state_t                       state_q, state_d;
    logic [ADDR_W-1:BYTE_OFF_W]   addr_q, addr_d;
    logic                         abandon_q, abandon_d;
    logic                         ready_q, ready_d;
    logic [WORD_W-1:0]            rdata_q, rdata_d;
    logic                         mreq_valid_q, mreq_valid_d;
    logic [ADDR_W-1:0]            mreq_addr_q, mreq_addr_d;
    logic                         hit_inc, miss_inc, fill_we;

    logic [TAG_W-1:0]             tag_q   [NUM_WAYS][NUM_SETS];
    logic [LINE_W-1:0]            data_q  [NUM_WAYS][NUM_SETS];
    logic [NUM_SETS-1:0]          valid_q [NUM_WAYS];

    logic [TAG_W-1:0]             req_tag, fill_tag;
    logic [SET_W-1:0]             req_set, fill_set;
    logic [OFF_W-1:0]             req_off, fill_off;
    logic [NUM_WAYS-1:0]          hit_vec, fill_valid_vec;
    logic [WAY_W-1:0]             hit_way, victim_c;
    logic [WORD_W-1:0]            hit_word, fill_word;
    logic                         evict_c;
    logic                         unused_c;

    function automatic logic [WORD_W-1:0] pick_word(input logic [LINE_W-1:0] line,
                                                    input logic [OFF_W-1:0]  off);
        pick_word = '0;
        for (int k = 0; k < int'(NUM_BLOCKS); k++) begin
            if (off == OFF_W'(k)) pick_word = line[k*WORD_W +: WORD_W];
        end
    endfunction

    assign req_tag   = bus.proc_addr[ADDR_W-1 -: TAG_W];
    assign req_set   = bus.proc_addr[LINE_OFF_W +: SET_W];
    assign req_off   = bus.proc_addr[BYTE_OFF_W +: OFF_W];
    assign fill_tag  = addr_q[ADDR_W-1 -: TAG_W];
    assign fill_set  = addr_q[LINE_OFF_W +: SET_W];
    assign fill_off  = addr_q[BYTE_OFF_W +: OFF_W];
    assign fill_word = pick_word(bus.mem_req_rdata, fill_off);
    assign unused_c  = ^bus.proc_addr[BYTE_OFF_W-1:0];

    // Parallel tag compare across all ways of the requested set
    always_comb begin
        hit_vec        = '0;
        hit_way        = '0;
        fill_valid_vec = '0;
        for (int w = 0; w < int'(NUM_WAYS); w++) begin
            hit_vec[w]        = valid_q[w][req_set] && (tag_q[w][req_set] == req_tag);
            fill_valid_vec[w] = valid_q[w][fill_set];
            if (hit_vec[w]) hit_way = WAY_W'(w);
        end
    end

    assign hit_word = pick_word(data_q[hit_way][req_set], req_off);
    assign evict_c  = fill_we && fill_valid_vec[victim_c];

    icache_nwa_wide_victim_sel #(
        .NUM_WAYS (NUM_WAYS),
        .NUM_SETS (NUM_SETS)
    ) u_victim (
        .clk       (clk),
        .reset     (reset),
        .set_idx   (fill_set),
        .way_valid (fill_valid_vec),
        .evict     (evict_c),
        .victim_c  (victim_c)
    );

    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        abandon_d    = abandon_q;
        ready_d      = 1'b0;
        rdata_d      = rdata_q;
        mreq_valid_d = mreq_valid_q;
        mreq_addr_d  = mreq_addr_q;
        hit_inc      = 1'b0;
        miss_inc     = 1'b0;
        fill_we      = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                // A flush cycle skips lookup so the request retries against the cleared tags
                if (bus.proc_valid && !bus.flush) begin
                    if (|hit_vec) begin
                        ready_d = 1'b1;
                        rdata_d = hit_word;
                        hit_inc = 1'b1;
                        state_d = S_RESP;
                    end else begin
                        addr_d       = bus.proc_addr[ADDR_W-1:BYTE_OFF_W];
                        abandon_d    = 1'b0;
                        mreq_valid_d = 1'b1;
                        mreq_addr_d  = {bus.proc_addr[ADDR_W-1:LINE_OFF_W], LINE_OFF_W'(0)};
                        miss_inc     = 1'b1;
                        state_d      = S_FILL;
                    end
                end
            end
            S_FILL: begin
                if (!bus.proc_valid) abandon_d = 1'b1;
                if (bus.mem_req_ready) begin
                    fill_we      = 1'b1;
                    mreq_valid_d = 1'b0;
                    if (bus.proc_valid && !abandon_q) begin
                        ready_d = 1'b1;
                        rdata_d = fill_word;
                        state_d = S_RESP;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            addr_q       <= '0;
            abandon_q    <= 1'b0;
            ready_q      <= 1'b0;
            rdata_q      <= '0;
            mreq_valid_q <= 1'b0;
            mreq_addr_q  <= '0;
            debug_miss   <= 1'b0;
            hit_count    <= '0;
            miss_count   <= '0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            abandon_q    <= abandon_d;
            ready_q      <= ready_d;
            rdata_q      <= rdata_d;
            mreq_valid_q <= mreq_valid_d;
            mreq_addr_q  <= mreq_addr_d;
            debug_miss   <= (state_d == S_FILL);
            if (hit_inc)  hit_count  <= sat_inc(hit_count);
            if (miss_inc) miss_count <= sat_inc(miss_count);
        end
    end

    // Flush is applied after the fill install so it wins on a coincident cycle
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int w = 0; w < int'(NUM_WAYS); w++) valid_q[w] <= '0;
        end else begin
            if (fill_we) valid_q[victim_c][fill_set] <= 1'b1;
            if (bus.flush) begin
                for (int w = 0; w < int'(NUM_WAYS); w++) valid_q[w] <= '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (fill_we) begin
            tag_q[victim_c][fill_set]  <= fill_tag;
            data_q[victim_c][fill_set] <= bus.mem_req_rdata;
        end
    end

    assign bus.proc_ready    = ready_q;
    assign bus.proc_rdata    = rdata_q;
    assign bus.mem_req_valid = mreq_valid_q;
    assign bus.mem_req_addr  = mreq_addr_q;

    a_onehot_hit: assert property (@(posedge clk) disable iff (reset)
        (state_q == S_IDLE && bus.proc_valid) |-> $onehot0(hit_vec));

endmodule
